prbs_gen_chk: RTL and testbench
===============================

# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker for the modulation test path, one clock domain. The generator is a Fibonacci LFSR of configurable length and polynomial with seed load and enable. The checker locks onto a received bit stream, flags bit errors and counts them, and drops lock after a run of errors. Generator output is looped to the checker input for BER self-test ahead of the modulator.

## Interface
- `WIDTH`, default 5: LFSR length, range 3..32.
- `TAPS`, default 5'b10100: feedback mask; bit i set means s[i] enters the XOR. The default gives x^5+x^3+1, period 31.
- `SEED`, default 1: generator state after reset. An all-zero value is replaced by 1.
- `VERIFY_N`, default 8: consecutive correct predictions required to declare lock.
- `LOSS_N`, default 4: consecutive mismatches while locked that force loss of lock.
- `CNT_W`, default 16: error counter width.
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-low reset.
- `en`  in  1: advance generator one step.
- `load`  in  1: load `seed` into generator.
- `seed`  in  WIDTH: runtime seed.
- `gen_bit`  out  1: generator output, equal to s[WIDTH-1].
- `gen_state`  out  WIDTH: generator register.
- `rx_bit`  in  1: received bit.
- `rx_valid`  in  1: `rx_bit` qualifier.
- `clr_cnt`  in  1: clear error counter.
- `locked`  out  1: checker lock status.
- `err`  out  1: one-cycle mismatch pulse (LOCKED state only).
- `err_cnt`  out  CNT_W: saturating error count.

## Operation
- Generator feedback: fb = XOR of s[i] over TAPS[i]=1. Each step, s <= {s[WIDTH-2:0], fb}.
- Generator priority: `load` beats `en`. A zero `seed` on load stores 1. The all-zero generator state is unreachable.
- Checker shift register c[WIDTH-1:0]. Prediction p = XOR of c[i] over TAPS[i]=1. The checker acts only on cycles with `rx_valid`=1; all checker state holds otherwise.
- FSM states are SEARCH, VERIFY and LOCKED. Reset state is SEARCH.
  - SEARCH: shift `rx_bit` into c and increment the fill count. When the fill count reaches WIDTH, clear the match count and go to VERIFY.
  - VERIFY: shift `rx_bit` into c.
    - Match: `rx_bit`==p and c!=0. Increment the match count. At VERIFY_N matches, go to LOCKED.
    - Mismatch, or c==0: clear the match count and stay in VERIFY.
  - LOCKED (flywheel): shift p into c, not `rx_bit`.
    - Mismatch: pulse `err`, increment `err_cnt`, increment the run count. When the run count reaches LOSS_N, go to SEARCH and clear the fill count.
    - Match: clear the run count.
- `err_cnt` saturates at 2^CNT_W-1. If `clr_cnt` and an error occur in the same cycle, the result is 1. `clr_cnt` alone gives 0.
- `locked` = (state==LOCKED), registered.

## Timing
- Reset (`rst`=0 at a clk edge) sets:
  - s to SEED (or 1 if SEED is zero);
  - `gen_bit` to SEED[WIDTH-1];
  - c to 0; `locked`, `err` and `err_cnt` to 0;
  - all checker counters to 0; FSM to SEARCH.
- Reset mid-operation has the same effect, with no partial state kept.
- `gen_bit` and `gen_state` update on the edge that samples `en`=1 or `load`=1. Latency is 1 cycle.
- `err` is registered. It goes high on the edge that samples the mismatching valid bit and lasts exactly 1 cycle per error. `err_cnt` updates on the same edge.
- `locked` rises on the edge that samples the (WIDTH+VERIFY_N)-th valid bit, given a clean stream from reset.
- `locked` falls on the edge that samples the LOSS_N-th consecutive mismatch. That bit still pulses `err` and is counted.
- Gaps in `rx_valid` do not affect lock, counts or predictions.

## Test plan
- Generator sequence (defaults): reset, then `en`=1. `gen_state` must read 00001, 00010, 00100, 01001, 10010 and `gen_bit` 0,0,0,0,1. The state returns to 00001 after exactly 31 steps, and 00000 never appears.
- Seed load: `seed`=0 with `load`=1 and `en`=1 in the same cycle must give `gen_state`=00001. `seed`=5'b10110 must give `gen_state`=10110.
- Loopback lock: `rx_bit`=`gen_bit`, `rx_valid`=`en`=1. `locked` must rise after 13 valid bits, with `err`=0 and `err_cnt`=0 for 200 cycles.
  - Repeat with `rx_valid` toggling every other cycle: lock must occur after 13 valid bits.
- Single error: while locked, invert one `rx_bit`. Required: exactly one `err` pulse, `err_cnt`=1, `locked` stays 1, and no further errors (flywheel).
  - Same cycle as a later error, assert `clr_cnt`: `err_cnt` must read 1.
- Loss of lock: while locked, invert 4 consecutive valid bits. Required: 4 `err` pulses, `err_cnt`=4, `locked` falls on the 4th.
  - Then restore the clean stream: relock after 13 further valid bits.
- Degenerate input and reset: `rx_bit`=0 constantly must never assert `locked`. With `CNT_W`=2 and 5 errors, `err_cnt` must saturate at 3. Dropping `rst` while locked must give `locked`=0, `err_cnt`=0 and `gen_state`=00001 on the next edge.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// PRBS generator (Fibonacci LFSR) with a self-synchronising checker that
// locks onto a received stream, flywheels through errors and counts them.
module prbs_gen_chk #(
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(5'b10100),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter int unsigned      VERIFY_N = 8,
  parameter int unsigned      LOSS_N   = 4,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             gen_bit,
  output logic [WIDTH-1:0] gen_state,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned      FILL_W   = $clog2(WIDTH + 1);
  localparam int unsigned      VER_W    = $clog2(VERIFY_N + 1);
  localparam int unsigned      LOSS_W   = $clog2(LOSS_N + 1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Generator: load has priority over en; a zero seed is forced to 1.
  logic [WIDTH-1:0] r_state;
  logic             w_fb;

  assign w_fb = ^(r_state & TAPS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SEED_EFF;
    end else if (load) begin
      r_state <= (seed == '0) ? WIDTH'(1) : seed;
    end else if (en) begin
      r_state <= {r_state[WIDTH-2:0], w_fb};
    end
  end

  assign gen_state = r_state;
  assign gen_bit   = r_state[WIDTH-1];

  // Checker state
  state_t            r_st,    w_st_nxt;
  logic [WIDTH-1:0]  r_c,     w_c_nxt;
  logic [FILL_W-1:0] r_fill,  w_fill_nxt;
  logic [VER_W-1:0]  r_match, w_match_nxt;
  logic [LOSS_W-1:0] r_run,   w_run_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic              r_err,   w_err_nxt;
  logic              r_locked;
  logic              w_pred;

  assign w_pred = ^(r_c & TAPS);

  // Next-state logic; nothing moves on cycles without rx_valid
  always_comb begin
    w_st_nxt    = r_st;
    w_c_nxt     = r_c;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_run_nxt   = r_run;
    w_err_nxt   = 1'b0;
    if (rx_valid) begin
      case (r_st)
        ST_SEARCH: begin
          w_c_nxt    = {r_c[WIDTH-2:0], rx_bit};
          w_fill_nxt = r_fill + FILL_W'(1);
          if (w_fill_nxt == FILL_W'(WIDTH)) begin
            w_match_nxt = '0;
            w_st_nxt    = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          w_c_nxt = {r_c[WIDTH-2:0], rx_bit};
          if ((rx_bit == w_pred) && (r_c != '0)) begin
            w_match_nxt = r_match + VER_W'(1);
            if (w_match_nxt == VER_W'(VERIFY_N)) begin
              w_run_nxt = '0;
              w_st_nxt  = ST_LOCKED;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: keep running on our own prediction, not the received bit
          w_c_nxt = {r_c[WIDTH-2:0], w_pred};
          if (rx_bit != w_pred) begin
            w_err_nxt = 1'b1;
            w_run_nxt = r_run + LOSS_W'(1);
            if (w_run_nxt == LOSS_W'(LOSS_N)) begin
              w_fill_nxt = '0;
              w_st_nxt   = ST_SEARCH;
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        default: begin
          w_st_nxt = ST_SEARCH;
        end
      endcase
    end
  end

  // Saturating error counter; clear and error together leave a count of one
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_cnt) begin
      w_cnt_nxt = w_err_nxt ? CNT_W'(1) : '0;
    end else if (w_err_nxt && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st     <= ST_SEARCH;
      r_c      <= '0;
      r_fill   <= '0;
      r_match  <= '0;
      r_run    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_st     <= w_st_nxt;
      r_c      <= w_c_nxt;
      r_fill   <= w_fill_nxt;
      r_match  <= w_match_nxt;
      r_run    <= w_run_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_st_nxt == ST_LOCKED);
    end
  end

  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_cnt;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: default instance plus a 2-bit counter
// instance sharing the same stimulus to exercise counter saturation.
module tb_prbs_gen_chk;

  logic        clk = 1'b0;
  logic        rst, en, load, rx_bit, rx_valid, clr_cnt;
  logic [4:0]  seed;
  logic        gen_bit, locked, err;
  logic [4:0]  gen_state;
  logic [15:0] err_cnt;
  logic        s_gen_bit, s_locked, s_err;
  logic [4:0]  s_gen_state;
  logic [1:0]  s_err_cnt;

  int checks   = 0;
  int failures = 0;

  prbs_gen_chk u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
    .gen_bit(gen_bit), .gen_state(gen_state),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  prbs_gen_chk #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
    .gen_bit(s_gen_bit), .gen_state(s_gen_state),
    .rx_bit(rx_bit), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
    .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One loopback bit, optionally inverted
  task automatic loop_bit(input logic inv);
    rx_bit   = gen_bit ^ inv;
    rx_valid = 1'b1;
    en       = 1'b1;
    tick();
  endtask

  // Feed 13 clean valid bits from reset/SEARCH; optional idle cycle before each
  task automatic lock_up(input string tag, input bit gap);
    for (int v = 1; v <= 13; v++) begin
      if (gap) begin
        rx_valid = 1'b0;
        en       = 1'b0;
        rx_bit   = ~gen_bit;
        tick();
        chk({tag, "_gap"}, 32'(locked), 32'(0));
      end
      loop_bit(1'b0);
      if (v >= 12) chk(tag, 32'(locked), 32'(v == 13));
    end
  endtask

  logic [4:0] exp_seq [4];
  int         period;
  bit         zero_seen;

  initial begin
    exp_seq = '{5'b00010, 5'b00100, 5'b01001, 5'b10010};
    rst = 1'b0; en = 1'b0; load = 1'b0; seed = 5'd0;
    rx_bit = 1'b0; rx_valid = 1'b0; clr_cnt = 1'b0;
    tick();
    chk("rst_state",  32'(gen_state), 32'h01);
    chk("rst_genbit", 32'(gen_bit),   32'(0));
    chk("rst_locked", 32'(locked),    32'(0));
    chk("rst_err",    32'(err),       32'(0));
    chk("rst_cnt",    32'(err_cnt),   32'(0));

    // Generator sequence and period
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gen_seq",    32'(gen_state), 32'(exp_seq[i]));
      chk("gen_bitseq", 32'(gen_bit),   32'(exp_seq[i][4]));
    end
    period    = 0;
    zero_seen = 1'b0;
    for (int k = 5; k <= 40; k++) begin
      tick();
      if (gen_state == 5'd0) zero_seen = 1'b1;
      if (gen_state == 5'd1) begin
        period = k;
        break;
      end
    end
    chk("gen_period", 32'(period),    32'(31));
    chk("gen_nozero", 32'(zero_seen), 32'(0));

    // Seed load beats enable; zero seed becomes 1
    load = 1'b1;
    seed = 5'd0;
    tick();
    chk("load_zero", 32'(gen_state), 32'h01);
    seed = 5'b10110;
    tick();
    chk("load_seed", 32'(gen_state), 32'h16);
    load = 1'b0;
    seed = 5'd0;

    // Loopback lock from reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lock_up("lock", 1'b0);
    for (int i = 0; i < 200; i++) begin
      loop_bit(1'b0);
      chk("clean_err",    32'(err),    32'(0));
      chk("clean_locked", 32'(locked), 32'(1));
    end
    chk("clean_cnt", 32'(err_cnt), 32'(0));

    // Single error, then flywheel keeps running clean
    loop_bit(1'b1);
    chk("single_err",    32'(err),       32'(1));
    chk("single_cnt",    32'(err_cnt),   32'(1));
    chk("single_locked", 32'(locked),    32'(1));
    chk("single_scnt",   32'(s_err_cnt), 32'(1));
    for (int i = 0; i < 20; i++) begin
      loop_bit(1'b0);
      chk("fly_err",    32'(err),    32'(0));
      chk("fly_locked", 32'(locked), 32'(1));
    end
    chk("fly_cnt", 32'(err_cnt), 32'(1));

    // Clear coinciding with an error leaves 1; clear alone gives 0
    clr_cnt = 1'b1;
    loop_bit(1'b1);
    clr_cnt = 1'b0;
    chk("clr_err_err",  32'(err),       32'(1));
    chk("clr_err_cnt",  32'(err_cnt),   32'(1));
    chk("clr_err_scnt", 32'(s_err_cnt), 32'(1));
    for (int i = 0; i < 5; i++) loop_bit(1'b0);
    clr_cnt = 1'b1;
    loop_bit(1'b0);
    clr_cnt = 1'b0;
    chk("clr_cnt",  32'(err_cnt),   32'(0));
    chk("clr_scnt", 32'(s_err_cnt), 32'(0));

    // Loss of lock after four consecutive errors
    for (int i = 1; i <= 4; i++) begin
      loop_bit(1'b1);
      chk("loss_err",    32'(err),     32'(1));
      chk("loss_cnt",    32'(err_cnt), 32'(i));
      chk("loss_locked", 32'(locked),  32'(i < 4));
    end
    chk("loss_scnt", 32'(s_err_cnt), 32'(3));
    lock_up("relock", 1'b0);

    // Fifth error since clear: small counter stays saturated
    loop_bit(1'b1);
    chk("sat_cnt",    32'(err_cnt),   32'(5));
    chk("sat_scnt",   32'(s_err_cnt), 32'(3));
    chk("sat_locked", 32'(locked),    32'(1));

    // Lock with rx_valid gapped every other cycle
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lock_up("gap_lock", 1'b1);
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b0;
      en       = 1'b0;
      rx_bit   = ~gen_bit;
      tick();
      loop_bit(1'b0);
      chk("gap_err",    32'(err),    32'(0));
      chk("gap_locked", 32'(locked), 32'(1));
    end
    chk("gap_cnt", 32'(err_cnt), 32'(0));

    // All-zero input must never lock
    rst = 1'b0;
    tick();
    rst      = 1'b1;
    en       = 1'b0;
    rx_valid = 1'b1;
    rx_bit   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("zero_locked", 32'(locked), 32'(0));
    end

    // Reset while locked clears everything on the next edge
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lock_up("lock3", 1'b0);
    loop_bit(1'b1);
    chk("pre_rst_cnt", 32'(err_cnt), 32'(1));
    rst = 1'b0;
    tick();
    chk("midrst_locked", 32'(locked),    32'(0));
    chk("midrst_cnt",    32'(err_cnt),   32'(0));
    chk("midrst_state",  32'(gen_state), 32'h01);
    chk("midrst_err",    32'(err),       32'(0));
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
